tnet_qick_cmd_issue: RTL and testbench
======================================

Name: tnet_qick_cmd_issue

Overview:
- Initiator side of the network control-command interface. Accepts one host/network command at a time (request type, op, relative delay) and converts a relative delay into an absolute 48-bit execution time.
- Drives the command executor's req/op/dt inputs for exactly one cycle, then tracks the executor's ack/ok handshake to completion.
- Reports a per-command result code and maintains saturating command/error counters. Resides in the t_clk domain beside the executor.

Parameters:
- TOUT_W, 16, width of the handshake timeout counter.
- TOUT_CYC, 1000, cycles allowed in WAIT_ACK, and in WAIT_DONE before ok/ack-drop (X_NOW, X_TIME only); must be < 2^TOUT_W.

Ports:
- t_clk_i  in  1  time clock.
- t_rst_ni  in  1  reset.
- t_time_abs_i  in  48  current absolute time.
- cmd_valid_i  in  1  host command valid.
- cmd_ready_o  out  1  block can accept a command.
- cmd_req_i  in  TYPE_CTRL_REQ  X_NOP/X_NOW/X_TIME/X_EXT.
- cmd_op_i  in  TYPE_CTRL_OP  operation code.
- cmd_dt_i  in  32  relative delay in t_clk ticks (X_TIME only).
- ctrl_cmd_req_o  out  TYPE_CTRL_REQ  request to executor.
- ctrl_cmd_op_o  out  TYPE_CTRL_OP  op to executor.
- ctrl_cmd_dt_o  out  48  absolute execution time to executor.
- ctrl_cmd_ack_i  in  1  executor busy/acknowledge.
- ctrl_cmd_ok_i  in  1  executor accepted timed command.
- res_valid_o  out  1  one-cycle result strobe.
- res_code_o  out  2  00 OK, 01 LATE, 10 TIMEOUT, 11 ILLEGAL.
- cnt_clr_i  in  1  synchronous clear of counters.
- cmd_cnt_o  out  16  completed commands, saturating.
- err_cnt_o  out  16  non-OK results, saturating.
- st_do  out  3  FSM state encoding.

Behaviour:
- Reset is t_rst_ni, asynchronous, active-low; clock is t_clk_i.
- All outputs are registered except cmd_ready_o.
- Reset values:
  - FSM = IDLE.
  - ctrl_cmd_req_o = X_NOP, ctrl_cmd_op_o = NOP, ctrl_cmd_dt_o = 0.
  - res_valid_o = 0, res_code_o = 00, counters = 0.
- cmd_ready_o = (state == IDLE) & !ctrl_cmd_ack_i.
- States:
  - IDLE = 1: on cmd_valid_i & cmd_ready_o (cycle n), latch req and op. Latch dt_abs = (t_time_abs_i + {16'd0, cmd_dt_i}) mod 2^48 for X_TIME, else 0.
    - If cmd_req_i == X_NOP: no issue; pulse res ILLEGAL at n+1; count as error; stay IDLE.
    - Otherwise go ISSUE.
  - ISSUE = 2: exactly one cycle (n+1). ctrl_cmd_req_o/op/dt carry the latched values during that cycle only; ctrl_cmd_req_o returns to X_NOP at n+2. Next state WAIT_ACK; clear timer and ok_seen.
  - WAIT_ACK = 3:
    - ctrl_cmd_ack_i = 1 → WAIT_DONE. Normal case: ack is observed at n+2.
    - Timer reaches TOUT_CYC → result TIMEOUT, go IDLE. No acknowledge means the executor never left idle.
  - WAIT_DONE = 4:
    - ok_seen |= ctrl_cmd_ok_i each cycle.
    - On ctrl_cmd_ack_i == 0, go IDLE and emit the result:
      - X_TIME: ok_seen ? OK : LATE.
      - X_NOW / X_EXT: OK.
    - Timer runs only while (req == X_NOW) or (req == X_TIME & !ok_seen). On expiry: result TIMEOUT → RECOVER.
    - X_EXT waits indefinitely for the external sync.
  - RECOVER = 5: no result; go IDLE when ctrl_cmd_ack_i == 0.
- Results:
  - res_valid_o pulses exactly one cycle, in the cycle after the terminating condition.
  - res_code_o updates with the strobe and holds until the next strobe.
  - Every strobe increments cmd_cnt_o; non-OK codes also increment err_cnt_o. Both saturate at 0xFFFF.
  - cnt_clr_i wins over a simultaneous increment.
- Boundaries:
  - dt_abs wraps mod 2^48 (no overflow flag).
  - cmd_dt_i = 0 is legal and normally yields LATE, since the executor applies its RTD check.
  - cmd_valid_i held while not ready: command is not consumed.
  - Reset mid-command: immediate return to IDLE; no result strobe; ctrl_cmd_req_o = X_NOP.
  - ctrl_cmd_ok_i outside WAIT_DONE is ignored.

Test Plan:
- X_TIME, t_time_abs = 1000, dt = 500, executor RTD = 100 → ctrl_cmd_dt_o = 1500 for 1 cycle; ack at n+2; ok high until time 1500; res OK; cmd_cnt = 1, err_cnt = 0.
- X_TIME, dt = 50, RTD = 100 → executor rejects (ack high 3 cycles, ok never high) → res LATE; err_cnt = 1.
- X_NOW with op QICK_CORE_START → ctrl_cmd_req_o = X_NOW one cycle, ctrl_cmd_dt_o = 0; ack high 1 cycle → res OK.
- Executor ack tied 0, TOUT_CYC = 8 → res TIMEOUT 8 cycles after WAIT_ACK entry; state IDLE; err_cnt = 1. Then cmd_req_i = X_NOP → res ILLEGAL next cycle; err_cnt = 2.
- t_time_abs = 2^48 − 10, dt = 20 → ctrl_cmd_dt_o = 10.
- X_EXT with no sync for 5000 cycles → no timeout, cmd_ready_o = 0; assert t_rst_ni low mid-wait → IDLE, req X_NOP, counters 0, no strobe.

Source files
------------

// File: rtl/tnet_qick_cmd_issue.sv
// Initiator side of the network control-command interface: converts a relative
// delay into an absolute 48-bit execution time and tracks the executor handshake.
module tnet_qick_cmd_issue #(
  parameter int unsigned TOUT_W   = 16,
  parameter int unsigned TOUT_CYC = 1000,
  parameter int unsigned OP_W     = 5
) (
  input  logic            t_clk_i,
  input  logic            t_rst_ni,
  input  logic [47:0]     t_time_abs_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_req_i,
  input  logic [OP_W-1:0] cmd_op_i,
  input  logic [31:0]     cmd_dt_i,
  output logic [1:0]      ctrl_cmd_req_o,
  output logic [OP_W-1:0] ctrl_cmd_op_o,
  output logic [47:0]     ctrl_cmd_dt_o,
  input  logic            ctrl_cmd_ack_i,
  input  logic            ctrl_cmd_ok_i,
  output logic            res_valid_o,
  output logic [1:0]      res_code_o,
  input  logic            cnt_clr_i,
  output logic [15:0]     cmd_cnt_o,
  output logic [15:0]     err_cnt_o,
  output logic [2:0]      st_do
);

  localparam logic [1:0]        X_NOP       = 2'd0;
  localparam logic [1:0]        X_NOW       = 2'd1;
  localparam logic [1:0]        X_TIME      = 2'd2;
  localparam logic [1:0]        X_EXT       = 2'd3;
  localparam logic [OP_W-1:0]   OP_NOP      = {OP_W{1'b0}};
  localparam logic [1:0]        RES_OK      = 2'd0;
  localparam logic [1:0]        RES_LATE    = 2'd1;
  localparam logic [1:0]        RES_TIMEOUT = 2'd2;
  localparam logic [1:0]        RES_ILLEGAL = 2'd3;
  localparam logic [15:0]       CNT_MAX     = 16'hFFFF;
  localparam logic [TOUT_W-1:0] TIMER_ZERO  = {TOUT_W{1'b0}};
  localparam logic [TOUT_W-1:0] TIMER_ONE   = TOUT_W'(1);
  // Timer counts 0..TOUT_CYC-1, so the last allowed cycle is the expiry point.
  localparam logic [TOUT_W-1:0] TIMER_LAST  = TOUT_W'(TOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RECOVER   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        req_q, req_d;
  logic [1:0]        ctrl_req_q, ctrl_req_d;
  logic [OP_W-1:0]   ctrl_op_q, ctrl_op_d;
  logic [47:0]       ctrl_dt_q, ctrl_dt_d;
  logic [TOUT_W-1:0] timer_q, timer_d;
  logic              ok_seen_q, ok_seen_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_code_q, res_code_d;
  logic [15:0]       cmd_cnt_q, cmd_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic              accept_s;
  logic [47:0]       dt_sum_s;
  logic              ok_any_s;
  logic              tout_hit_s;
  logic              timer_run_s;
  logic              res_fire_s;
  logic [1:0]        res_sel_s;

  assign cmd_ready_o = (state_q == ST_IDLE) & ~ctrl_cmd_ack_i;
  assign accept_s    = cmd_valid_i & cmd_ready_o;
  assign dt_sum_s    = t_time_abs_i + {16'd0, cmd_dt_i};
  assign ok_any_s    = ok_seen_q | ctrl_cmd_ok_i;
  assign tout_hit_s  = (timer_q == TIMER_LAST);
  // X_EXT never times out; X_TIME stops timing once the executor has accepted it.
  assign timer_run_s = (req_q == X_NOW) | ((req_q == X_TIME) & ~ok_any_s);

  // Command FSM next state, issue outputs and result selection.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ctrl_req_d = X_NOP;
    ctrl_op_d  = OP_NOP;
    ctrl_dt_d  = 48'd0;
    timer_d    = timer_q;
    ok_seen_d  = ok_seen_q;
    res_fire_s = 1'b0;
    res_sel_s  = RES_OK;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          req_d = cmd_req_i;
          if (cmd_req_i == X_NOP) begin
            res_fire_s = 1'b1;
            res_sel_s  = RES_ILLEGAL;
          end else begin
            state_d    = ST_ISSUE;
            ctrl_req_d = cmd_req_i;
            ctrl_op_d  = cmd_op_i;
            ctrl_dt_d  = (cmd_req_i == X_TIME) ? dt_sum_s : 48'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d   = ST_WAIT_ACK;
        timer_d   = TIMER_ZERO;
        ok_seen_d = 1'b0;
      end
      ST_WAIT_ACK: begin
        if (ctrl_cmd_ack_i) begin
          state_d = ST_WAIT_DONE;
          timer_d = TIMER_ZERO;
        end else if (tout_hit_s) begin
          state_d    = ST_IDLE;
          res_fire_s = 1'b1;
          res_sel_s  = RES_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_WAIT_DONE: begin
        ok_seen_d = ok_any_s;
        if (!ctrl_cmd_ack_i) begin
          state_d    = ST_IDLE;
          res_fire_s = 1'b1;
          if (req_q == X_TIME) begin
            res_sel_s = ok_any_s ? RES_OK : RES_LATE;
          end else begin
            res_sel_s = RES_OK;
          end
        end else if (timer_run_s && tout_hit_s) begin
          state_d    = ST_RECOVER;
          res_fire_s = 1'b1;
          res_sel_s  = RES_TIMEOUT;
        end else if (timer_run_s) begin
          timer_d = timer_q + TIMER_ONE;
        end else begin
          timer_d = timer_q;
        end
      end
      ST_RECOVER: begin
        if (!ctrl_cmd_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result strobe and saturating counters; a clear beats a simultaneous increment.
  always_comb begin
    res_valid_d = res_fire_s;
    res_code_d  = res_fire_s ? res_sel_s : res_code_q;
    cmd_cnt_d   = cmd_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (cnt_clr_i) begin
      cmd_cnt_d = 16'd0;
      err_cnt_d = 16'd0;
    end else if (res_fire_s) begin
      if (cmd_cnt_q != CNT_MAX) begin
        cmd_cnt_d = cmd_cnt_q + 16'd1;
      end else begin
        cmd_cnt_d = cmd_cnt_q;
      end
      if ((res_sel_s != RES_OK) && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      cmd_cnt_d = cmd_cnt_q;
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      state_q     <= ST_IDLE;
      req_q       <= X_NOP;
      ctrl_req_q  <= X_NOP;
      ctrl_op_q   <= OP_NOP;
      ctrl_dt_q   <= 48'd0;
      timer_q     <= TIMER_ZERO;
      ok_seen_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_code_q  <= RES_OK;
      cmd_cnt_q   <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ctrl_req_q  <= ctrl_req_d;
      ctrl_op_q   <= ctrl_op_d;
      ctrl_dt_q   <= ctrl_dt_d;
      timer_q     <= timer_d;
      ok_seen_q   <= ok_seen_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
      cmd_cnt_q   <= cmd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ctrl_cmd_req_o = ctrl_req_q;
  assign ctrl_cmd_op_o  = ctrl_op_q;
  assign ctrl_cmd_dt_o  = ctrl_dt_q;
  assign res_valid_o    = res_valid_q;
  assign res_code_o     = res_code_q;
  assign cmd_cnt_o      = cmd_cnt_q;
  assign err_cnt_o      = err_cnt_q;
  assign st_do          = state_q;

endmodule

// File: tb/tb_tnet_qick_cmd_issue.sv
// Directed bench for tnet_qick_cmd_issue with a simple executor responder and a
// transaction-level model (expected issues/results keyed by cycle number).
module tb_tnet_qick_cmd_issue;

  localparam int unsigned TOUT = 8;
  localparam logic [1:0]  X_NOP = 2'd0, X_NOW = 2'd1, X_TIME = 2'd2, X_EXT = 2'd3;
  localparam logic [4:0]  OP_NOP = 5'd0, OP_START = 5'd1, OP_EXT = 5'd2, OP_B = 5'd3;
  localparam logic [1:0]  R_OK = 2'd0, R_LATE = 2'd1, R_TOUT = 2'd2, R_ILL = 2'd3;
  localparam logic [47:0] RTD = 48'd100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  logic [47:0] t_off = 48'd0;
  logic [47:0] t_now;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_req = X_NOP;
  logic [4:0]  cmd_op = OP_NOP;
  logic [31:0] cmd_dt = 32'd0;
  logic [1:0]  ctrl_cmd_req_o;
  logic [4:0]  ctrl_cmd_op_o;
  logic [47:0] ctrl_cmd_dt_o;
  logic        ack = 1'b0;
  logic        ok = 1'b0;
  logic        res_valid_o;
  logic [1:0]  res_code_o;
  logic        cnt_clr = 1'b0;
  logic [15:0] cmd_cnt_o;
  logic [15:0] err_cnt_o;
  logic [2:0]  st_do;

  tnet_qick_cmd_issue #(.TOUT_W(16), .TOUT_CYC(TOUT), .OP_W(5)) dut (
    .t_clk_i(clk), .t_rst_ni(rst_n), .t_time_abs_i(t_now),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_req_i(cmd_req), .cmd_op_i(cmd_op), .cmd_dt_i(cmd_dt),
    .ctrl_cmd_req_o(ctrl_cmd_req_o), .ctrl_cmd_op_o(ctrl_cmd_op_o), .ctrl_cmd_dt_o(ctrl_cmd_dt_o),
    .ctrl_cmd_ack_i(ack), .ctrl_cmd_ok_i(ok),
    .res_valid_o(res_valid_o), .res_code_o(res_code_o),
    .cnt_clr_i(cnt_clr), .cmd_cnt_o(cmd_cnt_o), .err_cnt_o(err_cnt_o), .st_do(st_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign t_now = t_off + 48'(cyc);

  // Executor responder: X_NOW acks 1 cycle (20 if exe_long), X_EXT acks forever,
  // X_TIME accepts (ack+ok until its time) if at least RTD ahead, else acks 3 cycles.
  logic        exe_dead = 1'b0;
  logic        exe_long = 1'b0;
  int          e_mode = 0;
  int          e_cnt = 0;
  logic [47:0] e_dt = 48'd0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0; ok <= 1'b0; e_mode <= 0; e_cnt <= 0; e_dt <= 48'd0;
    end else if (e_mode == 0) begin
      ack <= 1'b0; ok <= 1'b0;
      if (!exe_dead && ctrl_cmd_req_o != X_NOP) begin
        if (ctrl_cmd_req_o == X_NOW) begin
          e_mode <= 1; ack <= 1'b1; e_cnt <= exe_long ? 20 : 1;
        end else if (ctrl_cmd_req_o == X_EXT) begin
          e_mode <= 4; ack <= 1'b1;
        end else if ($signed(ctrl_cmd_dt_o - t_now) >= $signed(RTD)) begin
          e_mode <= 2; e_dt <= ctrl_cmd_dt_o;
          ack <= (t_now + 48'd1 < ctrl_cmd_dt_o); ok <= (t_now + 48'd1 < ctrl_cmd_dt_o);
        end else begin
          e_mode <= 1; ack <= 1'b1; e_cnt <= 3;
        end
      end
    end else if (e_mode == 1) begin
      if (e_cnt == 1) begin ack <= 1'b0; e_mode <= 0; end
      else e_cnt <= e_cnt - 1;
    end else if (e_mode == 2) begin
      if (t_now + 48'd1 < e_dt) begin ack <= 1'b1; ok <= 1'b1; end
      else begin ack <= 1'b0; ok <= 1'b0; e_mode <= 0; end
    end else begin
      ack <= 1'b1;
    end
  end

  typedef struct { int unsigned c; logic [1:0] req; logic [4:0] op; logic [47:0] dt; } iss_t;
  typedef struct { int unsigned c; logic [1:0] code; } res_t;
  iss_t iss_q[$];
  res_t res_q[$];

  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b0;
  logic [15:0] m_cmd = 16'd0, m_err = 16'd0;
  logic [1:0]  m_code = 2'd0;
  logic        prev_clr = 1'b0;
  logic [1:0]  e_req;
  logic [4:0]  e_op;
  logic [47:0] e_dtv;
  logic        e_val;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_cmd(input int unsigned n, input logic [1:0] req, input logic [4:0] op,
                            input logic [47:0] dt, input int unsigned s, input logic [1:0] code);
    iss_t i; res_t r;
    if (req != X_NOP) begin
      i.c = n + 1; i.req = req; i.op = op; i.dt = dt;
      iss_q.push_back(i);
    end
    r.c = s; r.code = code;
    res_q.push_back(r);
  endtask

  // Present a command from now and hold it until the cycle it must be accepted in.
  task automatic send(input logic [1:0] req, input logic [4:0] op, input logic [31:0] dt,
                      input int unsigned acc);
    cmd_valid = 1'b1; cmd_req = req; cmd_op = op; cmd_dt = dt;
    while (cyc < acc) begin
      chk("ready_low_while_busy", 48'(cmd_ready_o), 48'd0);
      @(posedge clk); #1;
    end
    chk("ready_at_accept", 48'(cmd_ready_o), 48'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_req = X_TIME; cmd_op = OP_B; cmd_dt = 32'd7;
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Per-cycle compare of every registered output against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cmd = 16'd0; m_err = 16'd0; m_code = R_OK; prev_clr = 1'b0;
    end else if (chk_en) begin
      e_req = X_NOP; e_op = OP_NOP; e_dtv = 48'd0; e_val = 1'b0;
      if (iss_q.size() > 0 && iss_q[0].c == cyc) begin
        e_req = iss_q[0].req; e_op = iss_q[0].op; e_dtv = iss_q[0].dt;
        void'(iss_q.pop_front());
      end
      if (prev_clr) begin m_cmd = 16'd0; m_err = 16'd0; end
      if (res_q.size() > 0 && res_q[0].c == cyc) begin
        e_val = 1'b1; m_code = res_q[0].code;
        if (!prev_clr) begin
          if (m_cmd != 16'hFFFF) m_cmd = m_cmd + 16'd1;
          if (m_code != R_OK && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        void'(res_q.pop_front());
      end
      chk("ctrl_req", 48'(ctrl_cmd_req_o), 48'(e_req));
      chk("ctrl_op", 48'(ctrl_cmd_op_o), 48'(e_op));
      chk("ctrl_dt", ctrl_cmd_dt_o, e_dtv);
      chk("res_valid", 48'(res_valid_o), 48'(e_val));
      chk("res_code", 48'(res_code_o), 48'(m_code));
      chk("cmd_cnt", 48'(cmd_cnt_o), 48'(m_cmd));
      chk("err_cnt", 48'(err_cnt_o), 48'(m_err));
      prev_clr = cnt_clr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned n;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 48'(st_do), 48'd1);
    chk("rst_req", 48'(ctrl_cmd_req_o), 48'd0);
    chk("rst_op", 48'(ctrl_cmd_op_o), 48'd0);
    chk("rst_dt", ctrl_cmd_dt_o, 48'd0);
    chk("rst_res_valid", 48'(res_valid_o), 48'd0);
    chk("rst_cnts", 48'({cmd_cnt_o, err_cnt_o}), 48'd0);
    rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    // X_TIME accepted: 1000 + 500 -> 1500, ack from n+2 until time 1500, OK.
    t_off = 48'd1000 - 48'(cyc); n = cyc;
    expect_cmd(n, X_TIME, OP_B, 48'd1500, n + 501, R_OK);
    send(X_TIME, OP_B, 32'd500, n);
    chk("t1_dt_lit", ctrl_cmd_dt_o, 48'd1500);
    chk("t1_req_lit", 48'(ctrl_cmd_req_o), 48'(X_TIME));
    wait_cyc(n + 501);
    chk("t1_strobe", 48'({res_valid_o, res_code_o}), 48'(3'b100));
    chk("t1_cnts", 48'({cmd_cnt_o, err_cnt_o}), {16'd0, 16'd1, 16'd0});

    // X_TIME too close -> LATE; a held X_NOW waits until the FSM is back in IDLE.
    t_off = 48'd2000 - 48'(cyc); n = cyc;
    expect_cmd(n, X_TIME, OP_B, 48'd2050, n + 6, R_LATE);
    expect_cmd(n + 6, X_NOW, OP_START, 48'd0, n + 10, R_OK);
    send(X_TIME, OP_B, 32'd50, n);
    send(X_NOW, OP_START, 32'd999, n + 6);
    chk("t3_req_lit", 48'(ctrl_cmd_req_o), 48'(X_NOW));
    chk("t3_dt_lit", ctrl_cmd_dt_o, 48'd0);
    wait_cyc(n + 11);
    chk("t3_cnts", 48'({cmd_cnt_o, err_cnt_o}), {16'd0, 16'd3, 16'd1});

    // Dead executor -> TIMEOUT TOUT cycles after WAIT_ACK entry, then X_NOP -> ILLEGAL.
    exe_dead = 1'b1; n = cyc;
    expect_cmd(n, X_TIME, OP_B, t_now + 48'd100, n + 2 + TOUT, R_TOUT);
    send(X_TIME, OP_B, 32'd100, n);
    wait_cyc(n + 2 + TOUT);
    chk("t4_strobe", 48'({res_valid_o, res_code_o}), 48'(3'b110));
    chk("t4_state_idle", 48'(st_do), 48'd1);
    exe_dead = 1'b0; n = cyc;
    expect_cmd(n, X_NOP, OP_NOP, 48'd0, n + 1, R_ILL);
    send(X_NOP, OP_START, 32'd0, n);
    chk("t4_illegal", 48'({res_valid_o, res_code_o}), 48'(3'b111));
    chk("t4_cnts", 48'({cmd_cnt_o, err_cnt_o}), {16'd0, 16'd5, 16'd3});

    // X_NOW whose ack outlasts the timer -> TIMEOUT, RECOVER until ack drops.
    exe_long = 1'b1; n = cyc;
    expect_cmd(n, X_NOW, OP_START, 48'd0, n + 11, R_TOUT);
    expect_cmd(n + 23, X_NOP, OP_NOP, 48'd0, n + 24, R_ILL);
    send(X_NOW, OP_START, 32'd0, n);
    fork
      begin wait_cyc(n + 15); chk("t4b_recover", 48'(st_do), 48'd5); end
      send(X_NOP, OP_NOP, 32'd0, n + 23);
    join
    exe_long = 1'b0;
    chk("t4b_cnts", 48'({cmd_cnt_o, err_cnt_o}), {16'd0, 16'd7, 16'd5});

    // Absolute time wraps mod 2^48.
    t_off = 48'hFFFF_FFFF_FFF6 - 48'(cyc); n = cyc;
    expect_cmd(n, X_TIME, OP_B, 48'd10, n + 6, R_LATE);
    send(X_TIME, OP_B, 32'd20, n);
    chk("t5_wrap_dt", ctrl_cmd_dt_o, 48'd10);
    wait_cyc(n + 6);

    // dt = 0 is legal and ends LATE.
    t_off = 48'd3000 - 48'(cyc); n = cyc;
    expect_cmd(n, X_TIME, OP_START, 48'd3000, n + 6, R_LATE);
    send(X_TIME, OP_START, 32'd0, n);
    wait_cyc(n + 6);
    chk("t6_late", 48'({res_valid_o, res_code_o}), 48'(3'b101));

    // Clear coinciding with an increment wins; counting resumes afterwards.
    n = cyc; cnt_clr = 1'b1;
    expect_cmd(n, X_NOP, OP_NOP, 48'd0, n + 1, R_ILL);
    send(X_NOP, OP_NOP, 32'd0, n);
    cnt_clr = 1'b0;
    chk("t7_clr_wins", 48'({cmd_cnt_o, err_cnt_o}), 48'd0);
    n = cyc;
    expect_cmd(n, X_NOP, OP_NOP, 48'd0, n + 1, R_ILL);
    send(X_NOP, OP_NOP, 32'd0, n);
    chk("t7_resume", 48'({cmd_cnt_o, err_cnt_o}), {16'd0, 16'd1, 16'd1});

    // X_EXT never times out; reset mid-wait returns to a clean IDLE.
    n = cyc;
    begin
      iss_t i;
      i.c = n + 1; i.req = X_EXT; i.op = OP_EXT; i.dt = 48'd0;
      iss_q.push_back(i);
    end
    send(X_EXT, OP_EXT, 32'd77, n);
    wait_cyc(n + 5000);
    chk("t8_not_ready", 48'(cmd_ready_o), 48'd0);
    chk("t8_wait_done", 48'(st_do), 48'd4);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_state", 48'(st_do), 48'd1);
    chk("t8_rst_req", 48'(ctrl_cmd_req_o), 48'(X_NOP));
    chk("t8_rst_cnts", 48'({cmd_cnt_o, err_cnt_o}), 48'd0);
    chk("t8_rst_nostrobe", 48'(res_valid_o), 48'd0);
    iss_q.delete(); res_q.delete();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal operation after reset.
    n = cyc;
    expect_cmd(n, X_NOW, OP_START, 48'd0, n + 4, R_OK);
    send(X_NOW, OP_START, 32'd5, n);
    wait_cyc(n + 5);
    chk("t9_cnts", 48'({cmd_cnt_o, err_cnt_o}), {16'd0, 16'd1, 16'd0});

    chk("model_iss_drained", 48'(iss_q.size()), 48'd0);
    chk("model_res_drained", 48'(res_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
